// File: rtl/key_event_ctrl.sv
// Multi-key event controller: classifies per-key press activity into SHORT/LONG/LONG_REL
// events, holds them in one-entry slots and round-robins them into a shared event FIFO.
module key_event_ctrl #(
    parameter int NKEY       = 4,
    parameter int LONG_CNT   = 25_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NKEY-1:0]         key_flag,
    input  logic [NKEY-1:0]         key_state,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(NKEY)-1:0] evt_key,
    output logic [1:0]              evt_type,
    output logic                    overflow,
    input  logic                    clr_ovf
);
    // state  | meaning
    // S_IDLE | key released, waiting for a press flag
    // S_HELD | key pressed, hold counter running toward LONG_CNT-1
    // S_LONG | long press already reported, waiting for release
    localparam int KW = $clog2(NKEY);
    localparam int CW = $clog2(LONG_CNT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_TC    = CW'(LONG_CNT - 1);
    localparam logic [KW-1:0] KEY_LAST  = KW'(NKEY - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]    EVT_SHORT = 2'b00;
    localparam logic [1:0]    EVT_LONG  = 2'b01;
    localparam logic [1:0]    EVT_LREL  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} key_st_e;

    logic [NKEY-1:0] slot_v;
    logic [NKEY-1:0] drop;
    logic [1:0]      slot_t [NKEY];
    logic [KW-1:0]   last_grant;
    logic [KW-1:0]   gnt_idx;
    logic [KW-1:0]   cand;
    logic            gnt_any;
    logic            push;
    logic            pop;
    logic [KW+1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    for (genvar k = 0; k < NKEY; k++) begin : g_key
        key_st_e       st;
        logic [CW-1:0] cnt;
        logic          rv;
        logic [1:0]    rt;
        logic          sv;
        logic [1:0]    stype;
        logic          gnt_here;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                st  <= S_IDLE;
                cnt <= '0;
                rv  <= 1'b0;
                rt  <= EVT_SHORT;
            end else begin
                rv <= 1'b0;
                case (st)
                    S_IDLE: begin
                        if (key_flag[k] && !key_state[k]) begin
                            st  <= S_HELD;
                            cnt <= '0;
                        end
                    end
                    S_HELD: begin
                        if (cnt != CNT_TC) cnt <= cnt + 1'b1;
                        // a release in the terminal-count cycle still reports SHORT
                        if (key_flag[k] && key_state[k]) begin
                            rv <= 1'b1;
                            rt <= EVT_SHORT;
                            st <= S_IDLE;
                        end else if (cnt == CNT_TC) begin
                            rv <= 1'b1;
                            rt <= EVT_LONG;
                            st <= S_LONG;
                        end
                    end
                    S_LONG: begin
                        if (key_flag[k] && key_state[k]) begin
                            rv <= 1'b1;
                            rt <= EVT_LREL;
                            st <= S_IDLE;
                        end
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end

        assign gnt_here = push && (gnt_idx == KW'(k));
        assign drop[k]  = rv && sv && !gnt_here;

        // a slot being granted this edge may be refilled by a fresh event
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sv    <= 1'b0;
                stype <= EVT_SHORT;
            end else if (rv) begin
                if (!sv || gnt_here) begin
                    sv    <= 1'b1;
                    stype <= rt;
                end
            end else if (gnt_here) begin
                sv <= 1'b0;
            end
        end

        assign slot_v[k] = sv;
        assign slot_t[k] = stype;
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = last_grant;
        for (int i = 0; i < NKEY; i++) begin
            cand = (cand == KEY_LAST) ? '0 : cand + 1'b1;
            if (!gnt_any && slot_v[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (count == FIFO_FULL) gnt_any = 1'b0;
    end

    assign push = gnt_any;
    assign pop  = evt_valid && evt_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= KEY_LAST;
            overflow   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {gnt_idx, slot_t[gnt_idx]};
                wr_ptr      <= wr_ptr + 1'b1;
                last_grant  <= gnt_idx;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (|drop)        overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign evt_valid           = (count != '0);
    assign {evt_key, evt_type} = mem[rd_ptr];

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios plus random traffic, scored against
// a queue-based reference model that predicts every event the consumer should see.
module tb_key_event_ctrl;
    localparam int NKEY       = 4;
    localparam int LONG_CNT   = 8;
    localparam int FIFO_DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NKEY-1:0] key_flag = '0;
    logic [NKEY-1:0] key_state = '1;
    logic            evt_ready = 1'b0;
    logic            clr_ovf = 1'b0;
    logic            evt_valid;
    logic [1:0]      evt_key;
    logic [1:0]      evt_type;
    logic            overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q [$];
    int seen_q [$];

    key_event_ctrl #(.NKEY(NKEY), .LONG_CNT(LONG_CNT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .key_flag(key_flag), .key_state(key_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
        .evt_type(evt_type), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 pressed, 2 long reported. Events are key*4+type.
    int     m_phase [NKEY];
    longint m_press [NKEY];
    bit     m_rv [NKEY];
    int     m_rt [NKEY];
    bit     m_sv [NKEY];
    int     m_st [NKEY];
    int     m_fifo [$];
    int     m_last = NKEY - 1;
    bit     m_ovf = 1'b0;
    longint cyc = 0;

    always @(posedge clk) begin
        int g;
        int ev;
        bit dropped;
        cyc++;
        if (!rst_n) begin
            for (int k = 0; k < NKEY; k++) begin
                m_phase[k] = 0; m_rv[k] = 0; m_sv[k] = 0;
            end
            m_fifo.delete();
            exp_q.delete();
            m_last = NKEY - 1;
            m_ovf  = 0;
        end else begin
            g = -1;
            if (m_fifo.size() < FIFO_DEPTH)
                for (int i = 1; i <= NKEY; i++)
                    if (g < 0 && m_sv[(m_last + i) % NKEY]) g = (m_last + i) % NKEY;
            if (m_fifo.size() > 0 && evt_ready) void'(m_fifo.pop_front());
            if (g >= 0) begin
                ev = g * 4 + m_st[g];
                m_fifo.push_back(ev);
                exp_q.push_back(ev);
                m_sv[g] = 0;
                m_last  = g;
            end
            dropped = 0;
            for (int k = 0; k < NKEY; k++)
                if (m_rv[k]) begin
                    if (m_sv[k]) dropped = 1;
                    else begin m_sv[k] = 1; m_st[k] = m_rt[k]; end
                end
            if (dropped) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            for (int k = 0; k < NKEY; k++) begin
                m_rv[k] = 0;
                if (m_phase[k] == 0) begin
                    if (key_flag[k] && !key_state[k]) begin m_phase[k] = 1; m_press[k] = cyc; end
                end else if (m_phase[k] == 1) begin
                    if (key_flag[k] && key_state[k]) begin
                        m_rv[k] = 1; m_rt[k] = 0; m_phase[k] = 0;
                    end else if (cyc - m_press[k] == LONG_CNT) begin
                        m_rv[k] = 1; m_rt[k] = 1; m_phase[k] = 2;
                    end
                end else if (key_flag[k] && key_state[k]) begin
                    m_rv[k] = 1; m_rt[k] = 2; m_phase[k] = 0;
                end
            end
        end
    end

    // Monitor: scores every accepted event and tracks valid/overflow against the model.
    initial forever begin
        @(negedge clk);
        #1;
        check("evt_valid", evt_valid, (m_fifo.size() != 0));
        check("overflow", overflow, m_ovf);
        if (evt_valid === 1'b1 && evt_ready) begin
            seen_q.push_back(int'({evt_key, evt_type}));
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL event: got key %0d type %0d, expected none", evt_key, evt_type);
            end else begin
                check("event", {evt_key, evt_type}, exp_q.pop_front());
            end
        end
    end

    task automatic pulse(input logic [NKEY-1:0] mask, input logic st);
        for (int k = 0; k < NKEY; k++) if (mask[k]) key_state[k] = st;
        key_flag = mask;
        @(negedge clk);
        key_flag = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            key_flag  = NKEY'($urandom);
            key_state = NKEY'($urandom);
        end
        @(negedge clk);
        check("rst_valid", evt_valid, 0);
        check("rst_key", evt_key, 0);
        check("rst_type", evt_type, 0);
        check("rst_ovf", overflow, 0);
        key_flag = '0; key_state = '1; rst_n = 1'b1;
        cycles(5);
        check("rst_quiet", evt_valid, 0);

        // short press on key 2
        seen_q.delete();
        pulse(4'b0100, 1'b0);
        cycles(2);
        pulse(4'b0100, 1'b1);
        cycles(1);
        check("short_early", evt_valid, 0);
        cycles(1);
        check("short_valid", evt_valid, 1);
        check("short_key", evt_key, 2);
        check("short_type", evt_type, 0);
        evt_ready = 1'b1;
        cycles(3);
        evt_ready = 1'b0;
        check("short_count", seen_q.size(), 1);

        // long press on key 1, then release
        seen_q.delete();
        pulse(4'b0010, 1'b0);
        cycles(9);
        check("long_early", evt_valid, 0);
        cycles(1);
        check("long_valid", evt_valid, 1);
        check("long_key", evt_key, 1);
        check("long_type", evt_type, 1);
        cycles(9);
        pulse(4'b0010, 1'b1);
        evt_ready = 1'b1;
        cycles(6);
        evt_ready = 1'b0;
        check("long_count", seen_q.size(), 2);
        if (seen_q.size() == 2) check("long_rel", seen_q[1], 1 * 4 + 2);

        // release exactly at the terminal-count cycle
        seen_q.delete();
        pulse(4'b0010, 1'b0);
        cycles(7);
        pulse(4'b0010, 1'b1);
        cycles(2);
        check("tc_valid", evt_valid, 1);
        check("tc_type", evt_type, 0);
        evt_ready = 1'b1;
        cycles(10);
        evt_ready = 1'b0;
        check("tc_count", seen_q.size(), 1);

        // round robin across all keys, twice
        rst_n = 1'b0; cycles(1); rst_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            pulse(4'b1111, 1'b0);
            cycles(2);
            seen_q.delete();
            evt_ready = 1'b1;
            pulse(4'b1111, 1'b1);
            cycles(8);
            check("rr_count", seen_q.size(), 4);
            for (int i = 0; i < 4; i++)
                if (i < seen_q.size()) check("rr_order", seen_q[i], i * 4);
        end
        evt_ready = 1'b0;

        // backpressure and overflow on key 0
        for (int i = 0; i < 6; i++) begin
            pulse(4'b0001, 1'b0);
            pulse(4'b0001, 1'b1);
        end
        cycles(3);
        check("bp_ovf", overflow, 1);
        check("bp_head", {evt_valid, evt_key, evt_type}, 5'b1_00_00);
        cycles(3);
        check("bp_hold", {evt_valid, evt_key, evt_type}, 5'b1_00_00);
        seen_q.delete();
        evt_ready = 1'b1;
        cycles(8);
        evt_ready = 1'b0;
        check("bp_drained", seen_q.size(), 5);
        check("bp_ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        cycles(1);
        clr_ovf = 1'b0;
        check("bp_ovf_clr", overflow, 0);

        // reset while key 3 is in LONG with two events queued
        pulse(4'b0001, 1'b0);
        pulse(4'b0001, 1'b1);
        pulse(4'b1000, 1'b0);
        cycles(10);
        check("mid_valid_pre", evt_valid, 1);
        rst_n = 1'b0; cycles(1); rst_n = 1'b1;
        check("mid_valid", evt_valid, 0);
        check("mid_key", {evt_key, evt_type}, 0);
        seen_q.delete();
        pulse(4'b1000, 1'b1);
        evt_ready = 1'b1;
        cycles(5);
        check("mid_no_event", seen_q.size(), 0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            logic [NKEY-1:0] f;
            f = '0;
            for (int k = 0; k < NKEY; k++)
                if ($urandom_range(0, 5) == 0) begin
                    f[k] = 1'b1;
                    key_state[k] = 1'($urandom_range(0, 1));
                end
            key_flag  = f;
            evt_ready = ($urandom_range(0, 9) < 6);
            clr_ovf   = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 999) != 0);
            @(negedge clk);
        end
        key_flag = '0; clr_ovf = 1'b0; rst_n = 1'b1; evt_ready = 1'b1;
        cycles(30);
        check("drain_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Multi-key event controller that sits downstream of up to NKEY debounced key channels, one per key. Each channel supplies a one-cycle `key_flag` pulse and a level `key_state` (0 = pressed, 1 = released). The block classifies each key's activity into short-press, long-press and long-release events. It shares a single event queue between all keys using round-robin arbitration and presents queued events to a consumer over a valid/ready handshake.

## Interface
- `NKEY`, 4: number of key channels (2..8).
- `LONG_CNT`, 25_000_000: cycles a key must stay pressed to count as long (500 ms at 50 MHz); must be ≥ 2.
- `FIFO_DEPTH`, 4: event queue depth (power of two, ≥ 2).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `key_flag`  in  NKEY  per-key one-cycle pulse from the debouncer on a stable edge.
- `key_state`  in  NKEY  per-key debounced level; sampled only when the matching `key_flag` bit is 1.
- `evt_valid`  out  1  queue head holds an event.
- `evt_ready`  in  1  consumer accepts the head this cycle.
- `evt_key`  out  $clog2(NKEY)  key index of the head event.
- `evt_type`  out  2  event type: 00 SHORT, 01 LONG, 10 LONG_REL; 11 is never produced.
- `overflow`  out  1  sticky flag: at least one event was dropped.
- `clr_ovf`  in  1  clears `overflow` for one cycle; a drop in the same cycle wins.

## Operation
- **Per-key FSM**, one instance per key:
  - IDLE:
    - `key_flag` = 1 with `key_state` = 0 → HELD, hold counter cleared to 0.
    - `key_flag` = 1 with `key_state` = 1 is ignored.
  - HELD: counter increments every cycle.
    - `key_flag` = 1 with `key_state` = 1 → raise SHORT, go to IDLE.
    - Otherwise, counter == LONG_CNT-1 → raise LONG, go to LONG.
    - If release and terminal count coincide, release wins: SHORT is raised and LONG is not.
  - LONG:
    - `key_flag` = 1 with `key_state` = 1 → raise LONG_REL, go to IDLE.
    - Press flags are ignored.
  - The counter saturates, does not wrap, and is only meaningful in HELD.
- **Pending slots**: each key has a one-entry pending slot (valid bit plus type).
  - A raised event loads the slot.
  - If the slot is still occupied when a new event is raised, the new event is dropped and `overflow` is set. The FSM transition still occurs.
- **Arbiter**: each cycle, if the queue is not full (count < FIFO_DEPTH) and any slot is valid, it grants exactly one key.
  - The search starts at last_grant+1, modulo NKEY.
  - The granted slot is written to the queue and cleared in the same edge.
  - A slot being granted may be reloaded by a new event in that same edge; the new event is not a drop.
  - last_grant resets to NKEY-1, so key 0 has first priority.
- **Queue**: synchronous FIFO.
  - A push is allowed only when count < FIFO_DEPTH, judged before any pop in the same cycle.
  - Pop occurs when `evt_valid` & `evt_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - `evt_key`/`evt_type` are driven directly from the head entry and are held stable while `evt_valid` & !`evt_ready`.
- **Reset** (`rst_n` = 0 at a rising edge), effective at any point mid-operation:
  - All FSMs → IDLE, counters 0, slots empty, FIFO empty.
  - `evt_valid` = 0, `evt_key` = 0, `evt_type` = 00, `overflow` = 0, last_grant = NKEY-1.

## Timing
- Flag sampled at edge t:
  - Slot valid after edge t+1.
  - FIFO written at edge t+2.
  - `evt_valid` high in the cycle after edge t+2 when the queue was empty and the key was uncontended.
- LONG: raised at the edge where the counter equals LONG_CNT-1, i.e. LONG_CNT cycles after the edge that entered HELD.
- Throughput: at most one push and one pop per cycle. A single key can sustain one event per cycle through its slot if the queue drains.
- With all NKEY slots valid and the queue never full, every key is granted within NKEY cycles.
- `overflow` is set at the edge following the dropping cycle.

## Test plan
- **Reset**: hold `rst_n` = 0 for 3 cycles with random `key_flag` → all outputs at reset values; no event after release until a new flag.
- **Short press** (LONG_CNT = 8): key 2 press flag, release flag 3 cycles later → exactly one event, `evt_key` = 2, `evt_type` = 00, `evt_valid` rising 2 edges after the release flag.
- **Long press**: key 1 press held 20 cycles, then release → LONG at 8 cycles after entering HELD, then LONG_REL on release; no SHORT. Repeat with release exactly at the terminal-count cycle → only SHORT.
- **Round robin**: keys 0–3 all release-after-short in the same cycle, `evt_ready` = 1 → events emerge in order 0, 1, 2, 3. Repeat immediately → order continues from 0 after last grant 3.
- **Backpressure/overflow**: `evt_ready` = 0, FIFO_DEPTH = 4, 6 short presses on key 0 → queue holds 4 and the slot holds 1. The 6th event is dropped, `overflow` = 1, head stable. Then `evt_ready` = 1 → 5 events drained in order, and `clr_ovf` clears `overflow`.
- **Mid-operation reset**: key 3 in LONG with 2 events queued, assert `rst_n` = 0 for 1 cycle → queue empty, `evt_valid` = 0. A later release flag on key 3 produces no event (FSM in IDLE).
